// File: rtl/ebi_tx_serializer_if.sv
// Bus bundle for ebi_tx_serializer: per-channel message handshake plus the flit link.
// The DUT connects through the slave modport; the message source uses the master modport.
interface ebi_tx_serializer_if #(
    parameter int NUM_CH    = 4,
    parameter int PAYLOAD_W = 64,
    parameter int FLIT_W    = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]           ch_valid_i;
    logic [NUM_CH-1:0]           ch_ready_o;
    logic [NUM_CH*PAYLOAD_W-1:0] ch_payload_i;
    logic [NUM_CH-1:0]           credit_return_i;
    logic                        flit_valid_o;
    logic [FLIT_W-1:0]           flit_o;
    logic [CH_W-1:0]             flit_ch_o;
    logic                        flit_sof_o;
    logic                        flit_eof_o;
    logic                        flit_par_o;
    logic                        credit_err_o;

    modport master (
        output ch_valid_i, ch_payload_i, credit_return_i,
        input  ch_ready_o, flit_valid_o, flit_o, flit_ch_o,
        input  flit_sof_o, flit_eof_o, flit_par_o, credit_err_o
    );

    modport slave (
        input  ch_valid_i, ch_payload_i, credit_return_i,
        output ch_ready_o, flit_valid_o, flit_o, flit_ch_o,
        output flit_sof_o, flit_eof_o, flit_par_o, credit_err_o
    );
endinterface

// File: rtl/ebi_tx_serializer.sv
// Credit-gated round-robin message serializer: picks one channel, emits its payload LSB-first
// as NUM_BEATS flits. Define EBI_TX_PARITY_EN to drive even parity of each flit on flit_par_o.
module ebi_tx_serializer #(
    parameter int NUM_CH     = 4,
    parameter int PAYLOAD_W  = 64,
    parameter int FLIT_W     = 16,
    parameter int CREDIT_MAX = 4
) (
    input logic                bus_clk,
    input logic                rst,
    ebi_tx_serializer_if.slave bus
);
    localparam int NUM_BEATS = (PAYLOAD_W + FLIT_W - 1) / FLIT_W;
    localparam int PAD_W     = NUM_BEATS * FLIT_W;
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int CRED_W    = $clog2(CREDIT_MAX + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q;
    logic [BEAT_W-1:0] beat_q;
    logic [PAD_W-1:0]  rem_q;
    logic [FLIT_W-1:0] flit_q;
    logic [CH_W-1:0]   ch_q;
    logic [CH_W-1:0]   rr_q;
    logic              flit_valid_q;
    logic              sof_q;
    logic              eof_q;
    logic              err_q;
    logic              err_d;
    logic [CRED_W-1:0] cred_q [NUM_CH];
    logic [CRED_W-1:0] cred_d [NUM_CH];

    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] ready;
    logic [NUM_CH-1:0] accept;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_found;
    logic              arb_en;
    logic [PAD_W-1:0]  grant_pad;

    // A new message may start only while idle or on the last beat of the current one.
    assign arb_en = (state_q == IDLE) || eof_q;

    always_comb begin
        elig = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            elig[c] = bus.ch_valid_i[c] && (cred_q[c] != '0);
        end
    end

    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(rr_q) + i) % NUM_CH;
            if (!grant_found && elig[CH_W'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(idx);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (arb_en && grant_found) begin
            ready[grant_idx] = 1'b1;
        end
    end

    assign accept    = ready & bus.ch_valid_i;
    assign grant_pad = PAD_W'(bus.ch_payload_i[grant_idx*PAYLOAD_W +: PAYLOAD_W]);

    // Simultaneous take and return cancel; a return into a full counter is dropped and flagged.
    always_comb begin
        err_d = err_q;
        for (int c = 0; c < NUM_CH; c++) begin
            cred_d[c] = cred_q[c];
            if (accept[c] && !bus.credit_return_i[c]) begin
                cred_d[c] = cred_q[c] - 1'b1;
            end else if (!accept[c] && bus.credit_return_i[c]) begin
                if (cred_q[c] == CRED_W'(CREDIT_MAX)) begin
                    err_d = 1'b1;
                end else begin
                    cred_d[c] = cred_q[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge bus_clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cred_q[c] <= CRED_W'(CREDIT_MAX);
            end
            err_q <= 1'b0;
        end else begin
            cred_q <= cred_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            beat_q       <= '0;
            ch_q         <= '0;
            flit_valid_q <= 1'b0;
            flit_q       <= '0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
        end else if (arb_en && grant_found) begin
            state_q      <= SEND;
            rr_q         <= CH_W'((int'(grant_idx) + 1) % NUM_CH);
            ch_q         <= grant_idx;
            beat_q       <= '0;
            flit_valid_q <= 1'b1;
            flit_q       <= grant_pad[FLIT_W-1:0];
            rem_q        <= grant_pad >> FLIT_W;
            sof_q        <= 1'b1;
            eof_q        <= (NUM_BEATS == 1);
        end else if (state_q == SEND && !eof_q) begin
            beat_q <= beat_q + 1'b1;
            flit_q <= rem_q[FLIT_W-1:0];
            rem_q  <= rem_q >> FLIT_W;
            sof_q  <= 1'b0;
            eof_q  <= (int'(beat_q) + 2 == NUM_BEATS);
        end else begin
            state_q      <= IDLE;
            flit_valid_q <= 1'b0;
            flit_q       <= '0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
        end
    end

    assign bus.ch_ready_o   = ready;
    assign bus.flit_valid_o = flit_valid_q;
    assign bus.flit_o       = flit_q;
    assign bus.flit_ch_o    = ch_q;
    assign bus.flit_sof_o   = sof_q;
    assign bus.flit_eof_o   = eof_q;
    assign bus.credit_err_o = err_q;

    // flit_q is cleared whenever no flit is present, so its XOR is already 0 then.
`ifdef EBI_TX_PARITY_EN
    assign bus.flit_par_o = ^flit_q;
`else
    assign bus.flit_par_o = 1'b0;
`endif
endmodule
